// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch-queue entry layout.
package cpu_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; clear realigns rd to wr instead of
// zeroing both pointers so storage contents never need touching.
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: captures {pc, pc+4, instr} each fetch cycle and
// presents the oldest entry to ID, replacing the plain IF/ID register.
module if_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            flush_i,
    input  logic            id_ready_i,
    output logic            pcwrite_o,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc4_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic [AW:0]     count_o
);

    fetch_entry_t wr_entry, rd_entry;
    logic         full, empty, push, pop;

    // A redirect frees the PC even when full, since the queue is about to be emptied.
    assign pcwrite_o = start_i & (~full | flush_i);
    assign push      = start_i & ~full & ~flush_i;
    assign pop       = id_valid_o & id_ready_i & ~flush_i;

    assign wr_entry.pc    = pc_i;
    assign wr_entry.pc4   = pc_i + PC_STEP;
    assign wr_entry.instr = instr_i;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush_i),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

    always_comb begin
        id_valid_o = ~empty;
        id_pc_o    = '0;
        id_pc4_o   = '0;
        id_instr_o = NOP_INSTR;
        if (!empty) begin
            id_pc_o    = rd_entry.pc;
            id_pc4_o   = rd_entry.pc4;
            id_instr_o = rd_entry.instr;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios then random traffic
// checked against a queue-based reference model.
module tb_if_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i, id_ready_i;
    logic [31:0] pc_i, instr_i;
    logic        pcwrite_o, id_valid_o;
    logic [31:0] id_pc_o, id_pc4_o, id_instr_o;
    logic [AW:0] count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   model_valid = 1'b0;

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .flush_i    (flush_i),
        .id_ready_i (id_ready_i),
        .pcwrite_o  (pcwrite_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_pc4_o   (id_pc4_o),
        .id_instr_o (id_instr_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: an ordered list of fetched entries, at most DEPTH long.
    task automatic model_step();
        exp_t e;
        bit   full, do_pop, do_push;
        model_valid = 1'b1;
        if (!rst_i || flush_i) begin
            exp_q.delete();
        end else begin
            full    = (exp_q.size() == DEPTH);
            do_pop  = (exp_q.size() > 0) && id_ready_i;
            do_push = start_i && !full;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                e.pc    = pc_i;
                e.pc4   = pc_i + 32'd4;
                e.instr = instr_i;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic f, input logic rdy,
                                  input logic [31:0] pc, input logic [31:0] ins);
        @(posedge clk_i);
        model_step();
        #1;
        rst_i      = r;
        start_i    = s;
        flush_i    = f;
        id_ready_i = rdy;
        pc_i       = pc;
        instr_i    = ins;
    endtask

    always @(negedge clk_i) begin
        if (model_valid) begin
            check("count", 32'(count_o), 32'(exp_q.size()));
            check("valid", 32'(id_valid_o), 32'(exp_q.size() != 0));
            check("pcwrite", 32'(pcwrite_o),
                  32'(start_i & ((exp_q.size() < DEPTH) | flush_i)));
            if (exp_q.size() != 0) begin
                check("head_pc", id_pc_o, exp_q[0].pc);
                check("head_pc4", id_pc4_o, exp_q[0].pc4);
                check("head_instr", id_instr_o, exp_q[0].instr);
            end else begin
                check("empty_pc", id_pc_o, 32'h0);
                check("empty_pc4", id_pc4_o, 32'h0);
                check("empty_instr", id_instr_o, NOP_INSTR);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; id_ready_i = 1'b0;
        pc_i = 32'h0; instr_i = 32'h0;

        // Reset held two cycles, start high so pcwrite follows start.
        apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0);
        apply_stimulus(0, 1, 0, 0, 32'h0, 32'h0);

        // Streaming with ID always ready.
        apply_stimulus(1, 1, 0, 1, 32'h0, 32'hAAAA_0001);
        apply_stimulus(1, 1, 0, 1, 32'h4, 32'hBBBB_0002);
        apply_stimulus(1, 1, 0, 1, 32'h8, 32'hCCCC_0003);
        apply_stimulus(1, 0, 0, 1, 32'hC, 32'h0);
        apply_stimulus(1, 0, 0, 1, 32'hC, 32'h0);

        // Stall until full, release one cycle, then stall again.
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            apply_stimulus(1, 1, 0, 0, 32'(i * 4), 32'h1000_0000 + 32'(i));
        apply_stimulus(1, 1, 0, 1, 32'h10, 32'h1000_0004);
        apply_stimulus(1, 1, 0, 0, 32'h10, 32'h1000_0004);
        apply_stimulus(1, 0, 0, 1, 32'h14, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h14, 32'h0);

        // Flush while holding entries, then refetch from the target.
        apply_stimulus(1, 1, 1, 0, 32'h40, 32'h4040_4040);
        apply_stimulus(1, 1, 0, 1, 32'h40, 32'h4040_4040);
        apply_stimulus(1, 1, 0, 1, 32'h44, 32'h4444_4444);

        // Pointer wrap and PC+4 overflow.
        pc = 32'hFFFF_FFE8;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 1, 0, 1'(i % 2), pc, 32'h5000_0000 + 32'(i));
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 6; i++)
            apply_stimulus(1, 0, 0, 1, 32'h0, 32'h0);

        // Reset mid-run with two entries held.
        apply_stimulus(1, 1, 0, 0, 32'h100, 32'h6000_0001);
        apply_stimulus(1, 1, 0, 0, 32'h104, 32'h6000_0002);
        apply_stimulus(0, 0, 0, 0, 32'h108, 32'h0);
        apply_stimulus(1, 0, 0, 1, 32'h108, 32'h0);

        // Random traffic.
        pc = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, rdy;
            r   = ($urandom_range(0, 63) != 0);
            s   = ($urandom_range(0, 9) != 0);
            f   = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if (f) pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            else   pc = pc + 32'd4;
            apply_stimulus(r, s, f, rdy, pc, $urandom());
        end

        apply_stimulus(1, 0, 0, 1, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 1, 32'h0, 32'h0);
        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
